// File: rtl/uart_tx_arbiter.sv
// Four-way round-robin arbiter that feeds single bytes to a UART transmitter.
// After each byte is issued, it holds off new grants for one full frame time plus the idle gap.
module uart_tx_arbiter #(
  parameter int UART_BPS = 115200,
  parameter int CLK_FREQ = 50_000_000,
  parameter int GAP_BITS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_en,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  pi_data,
  output logic        pi_flag,
  output logic [1:0]  grant_id,
  output logic        busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int WAIT_CYCLES  = BAUD_CNT_MAX * (10 + GAP_BITS);
  localparam logic [19:0] CNT_END = 20'(WAIT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  win;
  logic        found;

  // The search starts at last+1 and ends at last itself, so a lone requester always wins.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req[last_q + 2'(k)]) begin
        win   = last_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (tx_en && found) begin
          state_d = SEND;
          last_d  = win;
          grant_d = win;
          data_d  = req_data[{win, 3'b000} +: 8];
        end
      end
      SEND: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == CNT_END) state_d = IDLE;
        else                  cnt_d   = cnt_q + 20'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 2'd3;
      grant_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
    end
  end

  assign pi_flag  = (state_q == SEND);
  assign ack      = pi_flag ? (4'b0001 << grant_q) : 4'b0000;
  assign pi_data  = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; uses a faster clock ratio (100 clocks per bit)
// so every frame-timing scenario fits in a short run.
module tb_uart_tx_arbiter;

  localparam int BPS    = 115200;
  localparam int CLK_HZ = 11_520_000;
  localparam int GAP    = 1;
  localparam int W      = (CLK_HZ / BPS) * (10 + GAP);  // 1100
  localparam int PERIOD = W + 1;                         // 1101 between strobes
  localparam int LIMIT  = PERIOD + 50;

  logic        sys_clk = 1'b0;
  logic        sys_rst, tx_en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  pi_data;
  logic        pi_flag;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.UART_BPS(BPS), .CLK_FREQ(CLK_HZ), .GAP_BITS(GAP)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_en(tx_en), .req(req),
    .req_data(req_data), .ack(ack), .pi_data(pi_data), .pi_flag(pi_flag),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_flag(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pi_flag && n < LIMIT);
    chk({tag, "_flag_seen"}, {31'd0, pi_flag}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < LIMIT) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, flags, seen3;
    sys_rst  = 1'b1;
    tx_en    = 1'b0;
    req      = 4'b0000;
    req_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
    tick();
    tick();
    chk("rst_flag",  {31'd0, pi_flag}, 32'd0);
    chk("rst_ack",   {28'd0, ack},     32'd0);
    chk("rst_busy",  {31'd0, busy},    32'd0);
    chk("rst_data",  {24'd0, pi_data}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    sys_rst = 1'b0;

    // Single requester 2: strobe one cycle after the IDLE decision, then one per period
    tx_en = 1'b1;
    req   = 4'b0100;
    tick();
    chk("s1_flag",  {31'd0, pi_flag}, 32'd1);
    chk("s1_ack",   {28'd0, ack},     32'b0100);
    chk("s1_data",  {24'd0, pi_data}, 32'hA5);
    chk("s1_grant", {30'd0, grant_id}, 32'd2);
    chk("s1_busy",  {31'd0, busy},    32'd1);
    wait_flag("s1_rep", n);
    chk("s1_period", n, PERIOD);
    chk("s1_rep_ack", {28'd0, ack}, 32'b0100);
    req = 4'b0000;
    wait_idle("s1");

    // All four after reset: order 0,1,2,3 starting from last=3
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      wait_flag("all", n);
      chk("all_grant", {30'd0, grant_id}, g);
      chk("all_ack",   {28'd0, ack}, 32'd1 << g);
      chk("all_data",  {24'd0, pi_data}, (req_data >> (8 * g)) & 32'hFF);
      if (g > 0) chk("all_period", n, PERIOD);
      req[g] = 1'b0;
    end
    wait_idle("all");
    flags = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pi_flag) flags++;
    end
    chk("all_no_extra", flags, 0);

    // Fairness: 0 and 2 held; last=3 so 0 first, then alternate
    req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      wait_flag("fair", n);
      chk("fair_grant", {30'd0, grant_id}, (g % 2 == 0) ? 32'd0 : 32'd2);
    end
    req = 4'b0000;
    wait_idle("fair");

    // tx_en gating: frame completes, nothing new until tx_en returns
    req = 4'b0001;
    wait_flag("gate", n);
    chk("gate_grant", {30'd0, grant_id}, 32'd0);
    for (int i = 0; i < 100; i++) tick();
    tx_en = 1'b0;
    chk("gate_busy_mid", {31'd0, busy}, 32'd1);
    wait_idle("gate");
    flags = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pi_flag) flags++;
    end
    chk("gate_no_flag", flags, 0);
    tx_en = 1'b1;
    wait_flag("gate_resume", n);
    chk("gate_resume_lat", n, 1);
    req = 4'b0000;
    wait_idle("gate2");

    // Reset 1000 cycles into WAIT; afterwards 0 beats 1 because last=3
    req = 4'b0010;
    wait_flag("mrst", n);
    chk("mrst_grant1", {30'd0, grant_id}, 32'd1);
    for (int i = 0; i < 1001; i++) tick();
    chk("mrst_in_wait", {31'd0, busy}, 32'd1);
    sys_rst = 1'b1;
    req     = 4'b0011;
    tick();
    chk("mrst_flag",  {31'd0, pi_flag}, 32'd0);
    chk("mrst_ack",   {28'd0, ack},     32'd0);
    chk("mrst_busy",  {31'd0, busy},    32'd0);
    chk("mrst_data",  {24'd0, pi_data}, 32'd0);
    chk("mrst_grant", {30'd0, grant_id}, 32'd0);
    sys_rst = 1'b0;
    tick();
    chk("mrst_rel_flag",  {31'd0, pi_flag}, 32'd1);
    chk("mrst_rel_grant", {30'd0, grant_id}, 32'd0);
    chk("mrst_rel_ack",   {28'd0, ack},     32'b0001);
    chk("mrst_rel_data",  {24'd0, pi_data}, 32'hC3);
    req = 4'b0000;
    wait_idle("mrst");

    // Withdrawal: req3 pulses during WAIT and must leave no trace
    req = 4'b0001;
    wait_flag("wd", n);
    chk("wd_grant0", {30'd0, grant_id}, 32'd0);
    n = 0;
    seen3 = 0;
    do begin
      tick();
      n++;
      if (n == 10)  req[3] = 1'b1;
      if (n == 200) req[3] = 1'b0;
      if (ack[3]) seen3 = 1;
    end while (!pi_flag && n < LIMIT);
    chk("wd_no_ack3", seen3, 0);
    chk("wd_period",  n, PERIOD);
    chk("wd_grant",   {30'd0, grant_id}, 32'd0);
    chk("wd_data",    {24'd0, pi_data}, 32'hC3);
    req = 4'b0000;
    wait_idle("wd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
